mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Two-requester arbiter sharing one 128-bit block memory port between the I-cache
//   and the D-cache (each the master side of its own write buffer).
//   One transaction in flight at a time; round-robin on contention.
//   Each cache side sees a private memory interface with a one-cycle ready pulse.
// PARAMETERS
//   ADDR_W   28    block address width (word address minus 2-bit word offset)
//   DATA_W   128   block data width (4 x 32-bit words)
// PORTS
//   clk        in   1       clock, all state on rising edge
//   proc_reset in   1       reset, asynchronous, active-high
//   i_read     in   1       I-side read request, level, held until i_ready
//   i_write    in   1       I-side write request, level, held until i_ready
//   i_addr     in   ADDR_W  I-side block address, stable while request high
//   i_wdata    in   DATA_W  I-side write block, stable while i_write high
//   i_rdata    out  DATA_W  I-side read block, valid when i_ready=1
//   i_ready    out  1       I-side completion pulse, exactly 1 cycle
//   d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as I-side, for D-cache
//   mem_read   out  1       memory read strobe, held until mem_ready
//   mem_write  out  1       memory write strobe, held until mem_ready
//   mem_addr   out  ADDR_W  memory block address
//   mem_wdata  out  DATA_W  memory write block
//   mem_rdata  in   DATA_W  memory read block, valid with mem_ready
//   mem_ready  in   1       memory completion, sampled only in S_BUSY
// BEHAVIOUR
//   Outputs: all registered. Reset value 0 for every output, incl. i_rdata/d_rdata.
//   Internal reset: state=S_IDLE, owner=I, last_grant=I, so D wins the first tie.
//   req_x = x_read | x_write.
//   S_IDLE:
//     - no req: stay.
//     - only one side requesting: grant it.
//     - both requesting: grant the side != last_grant.
//     - on grant at edge E:
//         latch owner, last_grant<=owner, mem_addr<=x_addr.
//         mem_write<=x_write, mem_read<=x_read & ~x_write.
//         write: mem_wdata<=x_wdata; read: mem_wdata unchanged.
//         -> S_BUSY. Strobe visible in the cycle after E.
//   S_BUSY:
//     - mem_read/mem_write/mem_addr/mem_wdata held constant.
//     - requester inputs ignored, incl. drop or change of request.
//     - on mem_ready at edge E:
//         clear both strobes.
//         owner read: owner rdata<=mem_rdata. Owner write: rdata unchanged.
//         owner ready<=1 for one cycle.
//         -> S_WAIT.
//   S_WAIT: one turnaround cycle.
//     - ready<=0, -> S_IDLE.
//     - The requester drops its request on the edge where it samples ready.
//     - Requests are not sampled in S_WAIT, so a completed request is never reissued.
//   Non-owner rdata: never changes. Non-owner ready: stays 0.
//   Latency, uncontended: request high before edge E0, mem strobe after E0.
//     - mem_ready sampled at edge Ek gives ready high in cycle after Ek.
//     - Next grant is possible at Ek+2.
//   Back-to-back, both sides always requesting: grants strictly alternate I/D, no starvation.
//   x_read & x_write both high: protocol error. Serviced as a write only; no read issued.
//   mem_ready outside S_BUSY: ignored.
//   proc_reset mid-transaction:
//     - all outputs to 0 immediately (async).
//     - the in-flight transaction is abandoned; no ready is pulsed.
//   Widths: pass-through only; no arithmetic. State encoding: 2 bits (IDLE/BUSY/WAIT).
// TESTING
//   1. I read 0x0000010, mem ready after 3 cycles, rdata=128'hA5..A5.
//      -> one mem_read with addr 0x0000010; i_ready 1 cycle; i_rdata=A5..A5; d_ready=0.
//   2. I and D both assert read in the same cycle after reset.
//      -> D granted first (mem_addr=d_addr), then I.
//      -> each ready pulses once, in D then I order.
//   3. D write 0x0000020 with data 128'h1, then D read 0x0000030 issued after d_ready.
//      -> mem_write then mem_read; d_rdata unchanged after the write.
//   4. Both sides requesting continuously for 6 transactions.
//      -> grants exactly D,I,D,I,D,I; no duplicate transaction per request.
//   5. proc_reset pulsed while S_BUSY with mem_read=1.
//      -> mem_read=0 and all outputs 0 in the same cycle; no ready pulse.
//      -> a fresh I read afterwards completes normally.
//   6. I request dropped mid-S_BUSY; spurious mem_ready in S_IDLE.
//      -> transaction completes with i_ready; spurious mem_ready produces no ready.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives the I-cache and D-cache shared use of one block memory port.
// Only one transaction is in flight at a time. Each side gets a one-cycle ready pulse when its transaction completes.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;

  logic              req_i, req_d;
  logic              grant_sel;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  // On a tie the side that did not win last time is granted.
  assign grant_sel = req_d & (~req_i | (last_grant_q == OWNER_I));

  assign sel_read  = (grant_sel == OWNER_D) ? d_read  : i_read;
  assign sel_write = (grant_sel == OWNER_D) ? d_write : i_write;
  assign sel_addr  = (grant_sel == OWNER_D) ? d_addr  : i_addr;
  assign sel_wdata = (grant_sel == OWNER_D) ? d_wdata : i_wdata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i | req_d) begin
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          mem_addr_d   = sel_addr;
          mem_write_d  = sel_write;
          mem_read_d   = sel_read & ~sel_write;
          if (sel_write) begin
            mem_wdata_d = sel_wdata;
          end
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWNER_D) begin
            d_ready_d = 1'b1;
            if (mem_read_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_ready_d = 1'b1;
            if (mem_read_q) begin
              i_rdata_d = mem_rdata;
            end
          end
          state_d = S_WAIT;
        end
      end
      // Turnaround cycle: requests are not looked at, so a finished request cannot be granted twice.
      S_WAIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

endmodule
